// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: EX operand forwarding selects, load-use stall, branch flush, multicycle EX hold.
// Latency: forwarding/stall/flush are combinational from stage fields; multicycle op occupies EX for MC_LAT cycles.
// Backpressure: stalls hold PC/IF-ID/ID-EX; bubbles are injected via flush_e (load-use) or flush_m (multicycle hold).
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_m,
  input  logic                  reg_write_w,
  input  logic                  load_e,
  input  logic                  mc_start_e,
  input  logic                  pc_src_e,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_m,
  output logic                  mc_busy,
  output logic                  mc_done
);

  localparam int CNT_W = $clog2(MC_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               mc_hold;
  logic               lu;

  // MEM result wins over WB result; x0 is hard-wired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rdm,
    input logic [REG_ADDR_W-1:0] rdw,
    input logic                  wm,
    input logic                  ww
  );
    if (wm && (rdm != '0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != '0) && (rdw == rs)) return 2'b01;
    else                                       return 2'b00;
  endfunction

  // Operand forwarding selects, valid also while EX is held since MEM/WB keep draining.
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, rd_m, rd_w, reg_write_m, reg_write_w);
    fwd_b_e = fwd_sel(rs2_e, rd_m, rd_w, reg_write_m, reg_write_w);
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  end

  // Multicycle sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Multicycle next state: first EX cycle holds from IDLE, BUSY counts down MC_LAT-2..0, last cycle releases.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_hold   = 1'b0;
    mc_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mc_start_e && !pc_src_e) begin
          mc_hold   = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = CNT_W'(MC_LAT - 2);
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mc_hold = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          mc_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mc_busy = (state == BUSY);

  // Stall/flush priority: taken branch, then multicycle hold, then load-use bubble.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (mc_hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: combinational vector table plus multicycle/reset sequences.
// Two instances (MC_LAT=4 and MC_LAT=2) share all inputs.
// Inputs change 1 ns after the rising edge; outputs are checked 3 ns after the rising edge.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_m, reg_write_w, load_e, mc_start_e, pc_src_e;

  logic [1:0] fa4, fb4, fa2, fb2;
  logic       sf4, sd4, se4, fd4, fe4, fm4, busy4, done4;
  logic       sf2, sd2, se2, fd2, fe2, fm2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .MC_LAT(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
    .fwd_a_e(fa4), .fwd_b_e(fb4),
    .stall_f(sf4), .stall_d(sd4), .stall_e(se4),
    .flush_d(fd4), .flush_e(fe4), .flush_m(fm4),
    .mc_busy(busy4), .mc_done(done4)
  );

  hazard_forward_ctrl #(.REG_ADDR_W(5), .MC_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .mc_start_e(mc_start_e), .pc_src_e(pc_src_e),
    .fwd_a_e(fa2), .fwd_b_e(fb2),
    .stall_f(sf2), .stall_d(sd2), .stall_e(se2),
    .flush_d(fd2), .flush_e(fe2), .flush_m(fm2),
    .mc_busy(busy2), .mc_done(done2)
  );

  // ctrl order: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  wire [5:0] ctrl4 = {sf4, sd4, se4, fd4, fe4, fm4};
  wire [5:0] ctrl2 = {sf2, sd2, se2, fd2, fe2, fm2};
  wire [11:0] all4 = {fa4, fb4, ctrl4, busy4, done4};
  wire [11:0] all2 = {fa2, fb2, ctrl2, busy2, done2};

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rwm, rww, load, pc;
    logic [1:0] exp_fa, exp_fb;
    logic [5:0] exp_ctrl;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  // Expected per-cycle results for mc_start_e held high over cycles T..T+4.
  logic [5:0] seq_ctrl4[5];
  logic [1:0] seq_bd4[5];
  logic [5:0] seq_ctrl2[5];
  logic [1:0] seq_bd2[5];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic clr_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0;
    load_e = 0; mc_start_e = 0; pc_src_e = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld  pc   fa     fb     ctrl
    vecs[0]  = '{0,   0,   3,   7,   0,  3,  3,  1,  1,  0,  0,  2'b10, 2'b00, 6'b000000};
    vecs[1]  = '{0,   0,   3,   7,   0,  3,  3,  0,  1,  0,  0,  2'b01, 2'b00, 6'b000000};
    vecs[2]  = '{0,   0,   0,   0,   0,  0,  0,  1,  1,  0,  0,  2'b00, 2'b00, 6'b000000};
    vecs[3]  = '{0,   0,   4,   9,   0,  9,  4,  1,  1,  0,  0,  2'b01, 2'b10, 6'b000000};
    vecs[4]  = '{0,   0,   1,   6,   0,  6,  6,  0,  1,  0,  0,  2'b00, 2'b01, 6'b000000};
    vecs[5]  = '{0,   5,   0,   0,   5,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 6'b110010};
    vecs[6]  = '{0,   5,   0,   0,   5,  0,  0,  0,  0,  0,  0,  2'b00, 2'b00, 6'b000000};
    vecs[7]  = '{5,   0,   0,   0,   5,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 6'b110010};
    vecs[8]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 6'b000000};
    vecs[9]  = '{5,   5,   0,   0,   5,  0,  0,  0,  0,  1,  1,  2'b00, 2'b00, 6'b000110};
    vecs[10] = '{2,   3,   0,   0,   0,  0,  0,  0,  0,  0,  1,  2'b00, 2'b00, 6'b000110};
    vecs[11] = '{0,   0,   8,   8,   0,  8,  8,  1,  0,  0,  0,  2'b10, 2'b10, 6'b000000};

    seq_ctrl4 = '{6'b111001, 6'b111001, 6'b111001, 6'b000000, 6'b111001};
    seq_bd4   = '{2'b00,     2'b10,     2'b10,     2'b11,     2'b00};
    seq_ctrl2 = '{6'b111001, 6'b000000, 6'b111001, 6'b000000, 6'b111001};
    seq_bd2   = '{2'b00,     2'b11,     2'b00,     2'b11,     2'b00};

    // Reset state: everything zero with quiet inputs.
    clr_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_u4", all4, 12'd0);
    chk("reset_u2", all2, 12'd0);
    #11 rst_n = 1'b1;

    // Combinational vectors (no multicycle start, FSM stays IDLE).
    for (int i = 0; i < NV; i++) begin
      step();
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
      rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      reg_write_m = vecs[i].rwm; reg_write_w = vecs[i].rww;
      load_e = vecs[i].load; pc_src_e = vecs[i].pc; mc_start_e = 1'b0;
      #2;
      chk($sformatf("vec%0d_fwd_a", i), {10'd0, fa4}, {10'd0, vecs[i].exp_fa});
      chk($sformatf("vec%0d_fwd_b", i), {10'd0, fb4}, {10'd0, vecs[i].exp_fb});
      chk($sformatf("vec%0d_ctrl", i), {6'd0, ctrl4}, {6'd0, vecs[i].exp_ctrl});
    end

    // Multicycle: mc_start_e high for T..T+4, forwarding inputs live during the hold.
    step();
    clr_inputs();
    rs1_e = 3; rd_m = 3; reg_write_m = 1'b1;
    mc_start_e = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      #2;
      chk($sformatf("mc4_ctrl_T%0d", c), {6'd0, ctrl4}, {6'd0, seq_ctrl4[c]});
      chk($sformatf("mc4_busy_done_T%0d", c), {10'd0, busy4, done4}, {10'd0, seq_bd4[c]});
      chk($sformatf("mc2_ctrl_T%0d", c), {6'd0, ctrl2}, {6'd0, seq_ctrl2[c]});
      chk($sformatf("mc2_busy_done_T%0d", c), {10'd0, busy2, done2}, {10'd0, seq_bd2[c]});
      chk($sformatf("mc4_fwd_hold_T%0d", c), {10'd0, fa4}, 12'b10);
    end
    step();
    mc_start_e = 1'b0;
    repeat (5) step();
    #2;
    chk("mc_drain_u4", all4, {2'b10, 10'd0});
    chk("mc_drain_u2", all2, {2'b10, 10'd0});

    // Branch taken while a multicycle start is presented: no hold, no BUSY.
    step();
    mc_start_e = 1'b1; pc_src_e = 1'b1;
    #2;
    chk("mc_vs_branch_ctrl", {6'd0, ctrl4}, {6'd0, 6'b000110});
    step();
    mc_start_e = 1'b0; pc_src_e = 1'b0;
    #2;
    chk("mc_vs_branch_busy", {10'd0, busy4, done4}, 12'd0);

    // Asynchronous reset in the middle of a BUSY sequence.
    step();
    clr_inputs();
    mc_start_e = 1'b1;
    step();
    #2;
    chk("rst_mid_busy_pre", {10'd0, busy4, se4}, 12'b11);
    rst_n = 1'b0;
    mc_start_e = 1'b0;
    #1;
    chk("rst_mid_busy_u4", all4, 12'd0);
    chk("rst_mid_busy_u2", all2, 12'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    #2;
    chk("post_rst_u4", all4, 12'd0);
    chk("post_rst_u2", all2, 12'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
